ericsmi_ddr_input_test: RTL and testbench

//  Tiny Tapeout DDR input-throughput tester. Samples ui_in on both edges of clk,

---
 rtl/ericsmi_ddr_input_test_if.sv | 13 +
 rtl/ericsmi_ddr_input_test.sv | 93 +++++++++
 tb/tb_ericsmi_ddr_input_test.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ericsmi_ddr_input_test_if.sv
// Tiny Tapeout user-pin bundle for the DDR input tester.
// The harness side (master) drives the inputs and the user block (slave) drives the outputs.
interface ericsmi_ddr_input_test_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (output ui_in, uio_in, ena, input  uo_out, uio_out, uio_oe);
  modport slave  (input  ui_in, uio_in, ena, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/ericsmi_ddr_input_test.sv
// DDR input-throughput tester: samples ui_in on both clock edges and checks lane 0
// against a self-synchronising 5-bit XNOR LFSR (next = ~(s[4]^s[2])).
module ericsmi_ddr_input_test #(
  parameter int unsigned ERR_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ericsmi_ddr_input_test_if.slave  bus
);
  localparam logic [2:0]       LOCK_BITS = 3'd5;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [7:0]       rise_q, fall_q;
  logic             valid_q;
  logic [1:0]       pair_q;
  logic [4:0]       s_q, s_d, s_mid;
  logic [2:0]       nbits_q, nbits_d, nbits_mid;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W:0]   err_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skew_q, skew_d;
  logic             locked, p0, p1, e0, e1, lanes_split;
  logic [1:0]       nerr;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) fall_q <= '0;
    else        fall_q <= bus.ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q  <= '0;
      valid_q <= 1'b0;
      pair_q  <= '0;
      s_q     <= '0;
      nbits_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      skew_q  <= 1'b0;
    end else begin
      rise_q  <= bus.ui_in;
      valid_q <= 1'b1;
      pair_q  <= {fall_q[0], rise_q[0]};
      s_q     <= s_d;
      nbits_q <= nbits_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      skew_q  <= skew_d;
    end
  end

  assign locked = (nbits_q == LOCK_BITS);

  // Two checker steps per cycle: the newer (fall) bit is predicted from the state
  // already advanced by the older (rise) bit, and may be the first bit checked.
  always_comb begin
    s_d       = s_q;
    nbits_d   = nbits_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    skew_d    = skew_q;

    p0        = ~(s_q[4] ^ s_q[2]);
    e0        = locked && (rise_q[0] != p0);
    s_mid     = {s_q[3:0], rise_q[0]};
    nbits_mid = locked ? nbits_q : nbits_q + 3'd1;
    p1        = ~(s_mid[4] ^ s_mid[2]);
    e1        = (nbits_mid == LOCK_BITS) && (fall_q[0] != p1);
    nerr      = {1'b0, e0} + {1'b0, e1};
    err_sum   = {1'b0, err_q} + (ERR_W+1)'(nerr);

    lanes_split = (rise_q[7:1] != {7{rise_q[0]}}) || (fall_q[7:1] != {7{fall_q[0]}});

    if (valid_q) begin
      s_d     = {s_mid[3:0], fall_q[0]};
      nbits_d = (nbits_mid == LOCK_BITS) ? nbits_mid : nbits_mid + 3'd1;
      err_d   = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];
      // Pair counting and skew use the lock state held at the start of the pair.
      if (locked) begin
        cnt_d  = cnt_q + CNT_W'(1);
        skew_d = skew_q | lanes_split;
      end
    end
  end

  assign bus.uo_out  = {4'(err_q), skew_q, locked, pair_q};
  assign bus.uio_out = 8'(cnt_q);
  assign bus.uio_oe  = 8'hFF;

  logic unused_inputs;
  assign unused_inputs = ^{bus.uio_in, bus.ena};
endmodule

// File: tb/tb_ericsmi_ddr_input_test.sv
// Self-checking bench for ericsmi_ddr_input_test with a bit-history reference model.
module tb_ericsmi_ddr_input_test;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ericsmi_ddr_input_test_if bus();

  ericsmi_ddr_input_test #(.ERR_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: full history of checked-lane bits since reset.
  bit          hist[$];
  int unsigned m_err, m_cnt;
  bit          m_skew, pend_v;
  logic [7:0]  pend_r, pend_f;
  logic [1:0]  m_pair;
  logic [4:0]  tl;

  function automatic void model_reset();
    hist.delete();
    m_err = 0; m_cnt = 0; m_skew = 0; pend_v = 0;
    pend_r = '0; pend_f = '0; m_pair = '0;
  endfunction

  function automatic void model_pair();
    int unsigned k;
    bit b[2];
    m_pair = {pend_f[0], pend_r[0]};
    if (!pend_v) return;
    if (hist.size() >= 5) begin
      m_cnt = (m_cnt + 1) % 256;
      if (pend_r != {8{pend_r[0]}} || pend_f != {8{pend_f[0]}}) m_skew = 1;
    end
    b[0] = pend_r[0];
    b[1] = pend_f[0];
    for (int i = 0; i < 2; i++) begin
      k = hist.size();
      if (k >= 5 && b[i] != !(hist[k-5] ^ hist[k-3]) && m_err < 15) m_err++;
      hist.push_back(b[i]);
    end
  endfunction

  function automatic logic [7:0] exp_uo();
    logic lk;
    lk = (hist.size() >= 5);
    return {4'(m_err), m_skew, lk, m_pair};
  endfunction

  function automatic logic lfsr_next();
    tl = {tl[3:0], ~(tl[4] ^ tl[2])};
    return tl[0];
  endfunction

  // Entry/exit point: 5 ns after a falling edge.
  task automatic drive_cycle(input logic [7:0] r, input logic [7:0] f);
    bus.ui_in = r;
    @(posedge clk);
    model_pair();
    pend_r = r;
    pend_v = 1;
    #5;
    bus.ui_in = f;
    pend_f = f;
    @(negedge clk);
    #5;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ui_in = '0;
    @(posedge clk);
    @(negedge clk);
    #5;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] r, f;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h expected 00", bus.uo_out); end
    checks++;
    if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio: got %h expected 00", bus.uio_out); end
    checks++;
    if (bus.uio_oe !== 8'hFF) begin errors++; $display("FAIL reset_oe: got %h expected FF", bus.uio_oe); end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      r = 8'($urandom);
      f = 8'($urandom);
      drive_cycle(r, f);
      checks++;
      if (bus.uo_out !== exp_uo()) begin errors++; $display("FAIL reset_first_pairs c%0d: got %h expected %h", c, bus.uo_out, exp_uo()); end
    end
  endtask

  task automatic test_lfsr();
    logic b0, b1;
    do_reset();
    tl = '0;
    for (int c = 0; c < 24; c++) begin
      b0 = lfsr_next();
      b1 = lfsr_next();
      drive_cycle({8{b0}}, {8{b1}});
      checks++;
      if (bus.uo_out !== exp_uo() || bus.uio_out !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL lfsr c%0d: got uo=%h uio=%h expected uo=%h uio=%h", c, bus.uo_out, bus.uio_out, exp_uo(), 8'(m_cnt));
      end
      if (c == 3) begin
        checks++;
        if (bus.uo_out[2] !== 1'b1) begin errors++; $display("FAIL lfsr_lock_time: got %b expected 1", bus.uo_out[2]); end
      end
    end
    checks++;
    if (bus.uo_out[7:3] !== 5'b0 || bus.uio_out !== 8'd20) begin
      errors++;
      $display("FAIL lfsr_clean: got err/skew=%h uio=%0d expected 00/20", bus.uo_out[7:3], bus.uio_out);
    end
  endtask

  task automatic test_single_flip();
    logic b0, b1;
    int unsigned fc, fh;
    do_reset();
    tl = 5'($urandom);
    fc = $urandom_range(3, 12);
    fh = $urandom_range(0, 1);
    for (int c = 0; c < 24; c++) begin
      b0 = lfsr_next();
      b1 = lfsr_next();
      if (c == fc && fh == 0) drive_cycle({{7{b0}}, ~b0}, {8{b1}});
      else if (c == fc)       drive_cycle({8{b0}}, {{7{b1}}, ~b1});
      else                    drive_cycle({8{b0}}, {8{b1}});
      checks++;
      if (bus.uo_out !== exp_uo() || bus.uio_out !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL flip c%0d: got uo=%h uio=%h expected uo=%h uio=%h", c, bus.uo_out, bus.uio_out, exp_uo(), 8'(m_cnt));
      end
    end
    checks++;
    if (bus.uo_out[7:3] !== 5'b0011_1) begin
      errors++;
      $display("FAIL flip_total: got err=%0d skew=%b expected err=3 skew=1", bus.uo_out[7:4], bus.uo_out[3]);
    end
  endtask

  task automatic test_zeros();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive_cycle(8'h00, 8'h00);
      checks++;
      if (bus.uo_out !== exp_uo()) begin errors++; $display("FAIL zeros c%0d: got %h expected %h", c, bus.uo_out, exp_uo()); end
      if (c == 4) begin
        checks++;
        if (bus.uo_out[7:4] !== 4'd3) begin errors++; $display("FAIL zeros_rate: got %0d expected 3", bus.uo_out[7:4]); end
      end
    end
    checks++;
    if (bus.uo_out[7:4] !== 4'hF) begin errors++; $display("FAIL zeros_sat: got %h expected F", bus.uo_out[7:4]); end
  endtask

  task automatic test_ones();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive_cycle(8'hFF, 8'hFF);
      checks++;
      if (bus.uo_out !== exp_uo()) begin errors++; $display("FAIL ones c%0d: got %h expected %h", c, bus.uo_out, exp_uo()); end
    end
    checks++;
    if (bus.uo_out !== 8'h07) begin errors++; $display("FAIL ones_final: got %h expected 07", bus.uo_out); end
  endtask

  task automatic test_lane_skew();
    logic b0, b1;
    do_reset();
    tl = '0;
    for (int c = 0; c < 20; c++) begin
      b0 = lfsr_next();
      b1 = lfsr_next();
      drive_cycle({1'b0, {7{b0}}}, {1'b0, {7{b1}}});
      checks++;
      if (bus.uo_out !== exp_uo()) begin errors++; $display("FAIL skew c%0d: got %h expected %h", c, bus.uo_out, exp_uo()); end
    end
    checks++;
    if (bus.uo_out[7:3] !== 5'b0000_1) begin
      errors++;
      $display("FAIL skew_final: got err=%0d skew=%b expected err=0 skew=1", bus.uo_out[7:4], bus.uo_out[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic b0, b1;
    do_reset();
    tl = '0;
    for (int c = 0; c < 10; c++) begin
      b0 = lfsr_next();
      b1 = lfsr_next();
      drive_cycle({8{b0}}, {8{b1}});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00 || bus.uio_oe !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got uo=%h uio=%h oe=%h expected 00 00 FF", bus.uo_out, bus.uio_out, bus.uio_oe);
    end
    @(negedge clk);
    #5;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      b0 = lfsr_next();
      b1 = lfsr_next();
      drive_cycle({8{b0}}, {8{b1}});
      checks++;
      if (bus.uo_out !== exp_uo() || bus.uio_out !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL relock c%0d: got uo=%h uio=%h expected uo=%h uio=%h", c, bus.uo_out, bus.uio_out, exp_uo(), 8'(m_cnt));
      end
    end
  endtask

  task automatic test_random();
    logic b0, b1;
    logic [7:0] r, f;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      tl = 5'($urandom);
      for (int c = 0; c < 30; c++) begin
        b0 = lfsr_next() ^ ($urandom_range(0, 19) == 0);
        b1 = lfsr_next() ^ ($urandom_range(0, 19) == 0);
        r = ($urandom_range(0, 9) == 0) ? {7'($urandom), b0} : {8{b0}};
        f = ($urandom_range(0, 9) == 0) ? {7'($urandom), b1} : {8{b1}};
        drive_cycle(r, f);
        checks++;
        if (bus.uo_out !== exp_uo() || bus.uio_out !== 8'(m_cnt)) begin
          errors++;
          $display("FAIL random r%0d c%0d: got uo=%h uio=%h expected uo=%h uio=%h", round, c, bus.uo_out, bus.uio_out, exp_uo(), 8'(m_cnt));
        end
      end
    end
  endtask

  initial begin
    bus.ui_in  = '0;
    bus.uio_in = '0;
    bus.ena    = 1'b1;
    model_reset();
    @(negedge clk);
    #5;
    test_reset();
    test_lfsr();
    test_single_flip();
    test_zeros();
    test_ones();
    test_lane_skew();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
